// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared SPI peripheral state encoding and opcode constants
`timescale 1ns/1ps
package spi_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_OPCODE  = 2'd1,
        ST_OPERAND = 2'd2
    } spi_state_t;

    localparam logic [7:0] OP_CAPTURE     = 8'h20;
    localparam logic [7:0] OP_BYTES_AVAIL = 8'h21;
    localparam logic [7:0] OP_READ_DATA   = 8'h22;

endpackage

// File: rtl/spi_sync.sv
// rtl/spi_sync.sv - multi-stage input synchroniser with preset idle level
`timescale 1ns/1ps
module spi_sync #(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic resetn,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] ff;

    // Shift the asynchronous input through the chain; preset to the idle level.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            ff <= {STAGES{RESET_VAL}};
        end else begin
            ff <= {ff[STAGES-2:0], d};
        end
    end

    assign q = ff[STAGES-1];

endmodule

// File: rtl/spi_peripheral.sv
// rtl/spi_peripheral.sv - SPI mode 0 peripheral with opcode/operand decode and response shifter
`timescale 1ns/1ps
module spi_peripheral
    import spi_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int COUNT_WIDTH = 32
) (
    input  logic                   clock_in,
    input  logic                   reset_n_in,
    input  logic                   sclk_in,
    input  logic                   cs_n_in,
    input  logic                   copi_in,
    output logic                   cipo_out,
    output logic [7:0]             op_code_out,
    output logic                   op_code_valid_out,
    output logic [7:0]             operand_out,
    output logic                   operand_valid_out,
    output logic [COUNT_WIDTH-1:0] operand_count_out,
    input  logic [7:0]             response_in,
    input  logic                   response_valid_in
);

    logic sclk_s, cs_n_s, copi_s;
    logic sclk_d, cs_n_d;
    logic sclk_rise, sclk_fall, cs_fall, cs_rise;
    logic [SYNC_STAGES-1:0] settle;
    logic armed;
    spi_state_t state, state_next;
    logic [2:0] bit_cnt;
    logic [7:0] rx_shift, rx_byte;
    logic       byte_done;
    logic [7:0] tx_shift;
    logic       tx_pending;

    spi_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
        .clk(clock_in), .resetn(reset_n_in), .d(sclk_in), .q(sclk_s));
    spi_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_cs (
        .clk(clock_in), .resetn(reset_n_in), .d(cs_n_in), .q(cs_n_s));
    spi_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_copi (
        .clk(clock_in), .resetn(reset_n_in), .d(copi_in), .q(copi_s));

    assign sclk_rise = sclk_s & ~sclk_d;
    assign sclk_fall = ~sclk_s & sclk_d;
    assign cs_fall   = ~cs_n_s & cs_n_d;
    assign cs_rise   = cs_n_s & ~cs_n_d;
    assign rx_byte   = {rx_shift[6:0], copi_s};
    assign byte_done = (state != ST_IDLE) && sclk_rise && (bit_cnt == 3'd7);

    // Edge-detect history, plus arming: after reset the preset cs_n level is not a
    // real sample, so a transaction may only start once a genuine high cs_n is seen.
    always_ff @(posedge clock_in) begin
        if (!reset_n_in) begin
            sclk_d <= 1'b0;
            cs_n_d <= 1'b1;
            settle <= '0;
            armed  <= 1'b0;
        end else begin
            sclk_d <= sclk_s;
            cs_n_d <= cs_n_s;
            settle <= {settle[SYNC_STAGES-2:0], 1'b1};
            armed  <= armed | (settle[SYNC_STAGES-1] & cs_n_s);
        end
    end

    // State register.
    always_ff @(posedge clock_in) begin
        if (!reset_n_in) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; a cs_n rise always wins the state, the datapath still takes the byte.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:    if (cs_fall && armed) state_next = ST_OPCODE;
            ST_OPCODE:  if (cs_rise) state_next = ST_IDLE;
                        else if (byte_done) state_next = ST_OPERAND;
            ST_OPERAND: if (cs_rise) state_next = ST_IDLE;
            default:    state_next = ST_IDLE;
        endcase
    end

    // Receive shifter and opcode/operand decode.
    always_ff @(posedge clock_in) begin
        if (!reset_n_in) begin
            bit_cnt           <= 3'd0;
            rx_shift          <= 8'h00;
            op_code_out       <= 8'h00;
            op_code_valid_out <= 1'b0;
            operand_out       <= 8'h00;
            operand_valid_out <= 1'b0;
            operand_count_out <= '0;
        end else begin
            operand_valid_out <= 1'b0;
            if (state == ST_IDLE) begin
                bit_cnt <= 3'd0;
            end else if (sclk_rise) begin
                rx_shift <= rx_byte;
                bit_cnt  <= bit_cnt + 3'd1;
            end
            if (byte_done && state == ST_OPCODE) begin
                op_code_out       <= rx_byte;
                op_code_valid_out <= 1'b1;
            end else if (state == ST_IDLE) begin
                op_code_valid_out <= 1'b0;
            end
            if (byte_done && state == ST_OPERAND) begin
                operand_out       <= rx_byte;
                operand_valid_out <= 1'b1;
                if (operand_count_out != {COUNT_WIDTH{1'b1}}) begin
                    operand_count_out <= operand_count_out + COUNT_WIDTH'(1);
                end
            end else if (state == ST_IDLE) begin
                operand_count_out <= '0;
            end
        end
    end

    // Transmit shifter: the first sclk fall after a completed byte loads the response.
    always_ff @(posedge clock_in) begin
        if (!reset_n_in) begin
            tx_shift   <= 8'h00;
            tx_pending <= 1'b0;
            cipo_out   <= 1'b0;
        end else if (state == ST_IDLE) begin
            tx_shift   <= 8'h00;
            tx_pending <= 1'b0;
            cipo_out   <= 1'b0;
        end else begin
            if (byte_done && state == ST_OPERAND || byte_done && state == ST_OPCODE) begin
                tx_pending <= 1'b1;
            end
            if (sclk_fall) begin
                if (tx_pending) begin
                    tx_pending <= 1'b0;
                    cipo_out   <= response_valid_in ? response_in[7] : 1'b0;
                    tx_shift   <= response_valid_in ? {response_in[6:0], 1'b0} : 8'h00;
                end else begin
                    cipo_out <= tx_shift[7];
                    tx_shift <= {tx_shift[6:0], 1'b0};
                end
            end
        end
    end

endmodule

// File: tb/tb_spi_peripheral.sv
// tb/tb_spi_peripheral.sv - scoreboard bench for spi_peripheral
`timescale 1ns/1ps
module tb_spi_peripheral;
    import spi_pkg::*;

    localparam int CW   = 32;
    localparam int HALF = 60;

    typedef struct packed {
        logic [7:0]    data;
        logic [CW-1:0] count;
    } opd_exp_t;

    logic          clock_in = 1'b0;
    logic          reset_n_in = 1'b0;
    logic          sclk_in = 1'b0;
    logic          cs_n_in = 1'b1;
    logic          copi_in = 1'b0;
    logic [7:0]    response_in = 8'h00;
    logic          response_valid_in = 1'b0;
    logic          cipo_out;
    logic [7:0]    op_code_out;
    logic          op_code_valid_out;
    logic [7:0]    operand_out;
    logic          operand_valid_out;
    logic [CW-1:0] operand_count_out;

    int total = 0;
    int bad = 0;
    int strobes = 0;
    int exp_strobes = 0;
    logic [7:0] exp_op_q[$];
    opd_exp_t   exp_opd_q[$];
    logic       op_valid_prev = 1'b0;
    opd_exp_t   mon_e;
    logic [7:0] rx;
    logic       seen_low;

    spi_peripheral #(.SYNC_STAGES(2), .COUNT_WIDTH(CW)) dut (
        .clock_in(clock_in), .reset_n_in(reset_n_in), .sclk_in(sclk_in),
        .cs_n_in(cs_n_in), .copi_in(copi_in), .cipo_out(cipo_out),
        .op_code_out(op_code_out), .op_code_valid_out(op_code_valid_out),
        .operand_out(operand_out), .operand_valid_out(operand_valid_out),
        .operand_count_out(operand_count_out), .response_in(response_in),
        .response_valid_in(response_valid_in));

    always #5 clock_in = ~clock_in;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h required %0h", name, got, exp);
        end
    endtask

    // Monitor: compare DUT decode outputs against the scoreboard queues.
    always @(negedge clock_in) begin
        if (reset_n_in) begin
            if (op_code_valid_out && !op_valid_prev) begin
                if (exp_op_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL opcode_unexpected: got %0h required none", op_code_out);
                end else begin
                    check("opcode", {24'h0, op_code_out}, {24'h0, exp_op_q.pop_front()});
                end
            end
            if (operand_valid_out) begin
                strobes++;
                if (exp_opd_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL operand_unexpected: got %0h required none", operand_out);
                end else begin
                    mon_e = exp_opd_q.pop_front();
                    check("operand", {24'h0, operand_out}, {24'h0, mon_e.data});
                    check("operand_count", operand_count_out, mon_e.count);
                end
            end
        end
        op_valid_prev = op_code_valid_out;
    end

    task automatic push_opd(input logic [7:0] d, input logic [CW-1:0] c);
        opd_exp_t e;
        e.data = d;
        e.count = c;
        exp_opd_q.push_back(e);
        exp_strobes++;
    endtask

    task automatic spi_bits(input logic [7:0] tx, input int n, output logic [7:0] r);
        r = 8'h00;
        for (int i = 0; i < n; i++) begin
            copi_in = tx[7-i];
            #HALF;
            r = {r[6:0], cipo_out};
            sclk_in = 1'b1;
            #HALF;
            sclk_in = 1'b0;
        end
        #HALF;
    endtask

    task automatic spi_byte(input logic [7:0] tx, output logic [7:0] r);
        spi_bits(tx, 8, r);
    endtask

    task automatic cs_low();
        cs_n_in = 1'b0;
        #HALF;
    endtask

    task automatic close_and_wait(input string name);
        int n;
        cs_n_in = 1'b1;
        n = 0;
        while ((op_code_valid_out || operand_count_out != 0) && n < 12) begin
            @(negedge clock_in);
            n++;
        end
        check({name, "_valid_drop"}, {31'h0, op_code_valid_out}, 32'h0);
        check({name, "_count_clear"}, operand_count_out, 32'h0);
        repeat (4) @(negedge clock_in);
    endtask

    task automatic check_reset_values(input string name);
        check({name, "_opcode"}, {24'h0, op_code_out}, 32'h0);
        check({name, "_opcode_valid"}, {31'h0, op_code_valid_out}, 32'h0);
        check({name, "_operand"}, {24'h0, operand_out}, 32'h0);
        check({name, "_operand_valid"}, {31'h0, operand_valid_out}, 32'h0);
        check({name, "_count"}, operand_count_out, 32'h0);
        check({name, "_cipo"}, {31'h0, cipo_out}, 32'h0);
    endtask

    initial begin
        repeat (5) @(negedge clock_in);
        check_reset_values("reset");
        reset_n_in = 1'b1;
        repeat (5) @(negedge clock_in);

        // Opcode-only transaction.
        exp_op_q.push_back(OP_CAPTURE);
        cs_low();
        spi_byte(OP_CAPTURE, rx);
        check("t1_cipo_byte0", {24'h0, rx}, 32'h0);
        check("t1_valid_before_rise", {31'h0, op_code_valid_out}, 32'h1);
        check("t1_count", operand_count_out, 32'h0);
        close_and_wait("t1");
        check("t1_opcode_hold", {24'h0, op_code_out}, 32'h20);

        // Single operand with a valid response.
        response_in = 8'h19;
        response_valid_in = 1'b1;
        exp_op_q.push_back(OP_BYTES_AVAIL);
        push_opd(8'h00, 1);
        cs_low();
        spi_byte(OP_BYTES_AVAIL, rx);
        check("t2_cipo_byte0", {24'h0, rx}, 32'h0);
        spi_byte(8'h00, rx);
        check("t2_cipo_resp", {24'h0, rx}, 32'h19);
        check("t2_count", operand_count_out, 32'h1);
        close_and_wait("t2");

        // Ten operands, response stepping 0x01..0x0A.
        exp_op_q.push_back(OP_READ_DATA);
        response_in = 8'h01;
        cs_low();
        spi_byte(OP_READ_DATA, rx);
        for (int k = 1; k <= 10; k++) begin
            push_opd(8'h00, CW'(k));
            response_in = 8'(k + 1);
            spi_byte(8'h00, rx);
            check("t3_cipo_resp", {24'h0, rx}, 32'(k));
        end
        check("t3_count", operand_count_out, 32'd10);
        close_and_wait("t3");

        // Partial operand discarded; response invalid gives 0x00.
        response_valid_in = 1'b0;
        response_in = 8'hEE;
        exp_op_q.push_back(OP_READ_DATA);
        push_opd(8'h5A, 1);
        cs_low();
        spi_byte(OP_READ_DATA, rx);
        spi_byte(8'h5A, rx);
        check("t4_cipo_invalid", {24'h0, rx}, 32'h0);
        spi_bits(8'hFF, 5, rx);
        check("t4_count_partial", operand_count_out, 32'h1);
        close_and_wait("t4");
        check("t4_operand_hold", {24'h0, operand_out}, 32'h5A);
        exp_op_q.push_back(OP_CAPTURE);
        cs_low();
        spi_byte(OP_CAPTURE, rx);
        check("t4_next_opcode", {24'h0, op_code_out}, 32'h20);
        close_and_wait("t4b");

        // Reset mid-operand, clocks ignored until a fresh cs_n fall.
        response_valid_in = 1'b1;
        response_in = 8'hC3;
        exp_op_q.push_back(OP_BYTES_AVAIL);
        cs_low();
        spi_byte(OP_BYTES_AVAIL, rx);
        spi_bits(8'hAA, 4, rx);
        reset_n_in = 1'b0;
        repeat (3) @(negedge clock_in);
        check_reset_values("t5_reset");
        reset_n_in = 1'b1;
        spi_bits(8'hAA, 4, rx);
        spi_byte(8'h22, rx);
        check("t5_ignored_valid", {31'h0, op_code_valid_out}, 32'h0);
        check("t5_ignored_opcode", {24'h0, op_code_out}, 32'h0);
        cs_n_in = 1'b1;
        repeat (6) @(negedge clock_in);
        exp_op_q.push_back(OP_BYTES_AVAIL);
        push_opd(8'h7E, 1);
        cs_low();
        spi_byte(OP_BYTES_AVAIL, rx);
        spi_byte(8'h7E, rx);
        check("t5_cipo_resp", {24'h0, rx}, 32'hC3);
        check("t5_count", operand_count_out, 32'h1);
        close_and_wait("t5");

        // Back-to-back transactions with a 4-cycle cs_n gap.
        exp_op_q.push_back(OP_CAPTURE);
        exp_op_q.push_back(OP_BYTES_AVAIL);
        cs_low();
        spi_byte(OP_CAPTURE, rx);
        cs_n_in = 1'b1;
        seen_low = 1'b0;
        repeat (4) begin
            @(negedge clock_in);
            if (!op_code_valid_out) seen_low = 1'b1;
        end
        cs_n_in = 1'b0;
        repeat (8) begin
            @(negedge clock_in);
            if (!op_code_valid_out) seen_low = 1'b1;
        end
        #HALF;
        spi_byte(OP_BYTES_AVAIL, rx);
        check("t6_valid_dropped", {31'h0, seen_low}, 32'h1);
        check("t6_valid_second", {31'h0, op_code_valid_out}, 32'h1);
        check("t6_opcode_second", {24'h0, op_code_out}, 32'h21);
        close_and_wait("t6");

        repeat (10) @(negedge clock_in);
        check("opcode_queue_empty", exp_op_q.size(), 32'h0);
        check("operand_queue_empty", exp_opd_q.size(), 32'h0);
        check("strobe_total", strobes, exp_strobes);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/spi_peripheral.md
SPI_PERIPHERAL -- requirements
Module: spi_peripheral

Interface
REQ-001 Parameter SYNC_STAGES, default 2, flip-flops in each input synchroniser (minimum 2).
REQ-002 Parameter COUNT_WIDTH, default 32, width of operand_count_out.
REQ-003 clock_in  input  1  system clock; sclk_in runs at most clock_in/8.
REQ-004 reset_n_in  input  1  reset; synchronous, active-low.
REQ-005 sclk_in  input  1  SPI clock from host, asynchronous; SPI mode 0.
REQ-006 cs_n_in  input  1  SPI chip select from host, asynchronous, active-low.
REQ-007 copi_in  input  1  host-to-peripheral data, MSB first.
REQ-008 cipo_out  output  1  peripheral-to-host data, MSB first.
REQ-009 op_code_out  output  8  first byte of the current transaction.
REQ-010 op_code_valid_out  output  1  op_code_out is valid for this transaction.
REQ-011 operand_out  output  8  most recent operand byte.
REQ-012 operand_valid_out  output  1  single-cycle strobe: new operand_out.
REQ-013 operand_count_out  output  COUNT_WIDTH  operands received this transaction.
REQ-014 response_in  input  8  response byte from the addressed block.
REQ-015 response_valid_in  input  1  response_in is valid.

Function
REQ-016 sclk_in, cs_n_in and copi_in SHALL each pass through a SYNC_STAGES synchroniser; edges are detected on the synchronised signals only.
REQ-017 States: IDLE (cs_n high), OPCODE (shifting byte 0), OPERAND (shifting byte 1+).
- IDLE -> OPCODE on synchronised cs_n falling edge; bit counter cleared.
- Any state -> IDLE on synchronised cs_n rising edge.
REQ-018 copi SHALL be sampled on each synchronised sclk rising edge; a byte completes on the 8th rising edge.
REQ-019 OPCODE byte completion: op_code_out loads the byte and op_code_valid_out goes high the next cycle; state -> OPERAND.
REQ-020 op_code_valid_out SHALL stay high until the cycle after cs_n rises, then go low; op_code_out holds its value.
REQ-021 OPERAND byte completion: operand_out loads the byte, operand_valid_out pulses high for exactly one cycle, and operand_count_out increments, all in the same cycle.
REQ-022 operand_count_out SHALL clear to 0 on return to IDLE and saturate at all-ones.
REQ-023 cipo_out SHALL shift on synchronised sclk falling edges. On the first falling edge after a byte completes, the shift register loads response_in if response_valid_in is high, otherwise 0x00, and presents bit 7. Each subsequent falling edge presents the next bit.
REQ-024 cipo_out SHALL output 0 during byte 0 and while in IDLE.
REQ-025 A partial byte at cs_n rise SHALL be discarded: no strobe, no count change, no op_code update.
REQ-026 sclk edges while cs_n is high SHALL be ignored.
REQ-027 If a byte-completion and a cs_n rise are detected in the same cycle, the byte SHALL be accepted first and the transaction then closed.

Reset
REQ-028 While reset_n_in is low at a clock edge, the block SHALL reset as follows:
- state IDLE;
- op_code_out, operand_out = 0x00;
- op_code_valid_out, operand_valid_out, cipo_out = 0;
- operand_count_out = 0;
- synchronisers preset to the idle levels (cs_n 1, sclk 0, copi 0).
REQ-029 Reset asserted mid-transaction SHALL abort the transaction. After release, the block SHALL wait for a fresh cs_n falling edge before accepting any byte.

Structure
REQ-030 The state enum and the SPI opcode constants (0x20 capture, 0x21 bytes available, 0x22 read data) SHALL live in a shared spi_pkg.
REQ-031 The input synchroniser SHALL be one sub-module, spi_sync, instanced three times.

Verification
REQ-032 Stimulus: cs_n low, byte 0x20, cs_n high.
- op_code_out = 0x20, op_code_valid_out high until 1 cycle after cs rise.
- operand_count_out stays 0.
REQ-033 Stimulus: 0x21 then one operand 0x00, with response_in = 0x19 and response_valid_in high.
- operand strobe once, count = 1.
- host reads 0x19 on cipo during the operand byte.
REQ-034 Stimulus: 0x22 then ten operands 0x00, response_in stepping 0x01..0x0A.
- ten single-cycle strobes, count 1..10.
- host reads bytes in order; count returns to 0 after cs rise.
REQ-035 Stimulus: cs_n rises after 5 bits of an operand.
- no strobe, count unchanged.
- next transaction decodes its opcode correctly.
REQ-036 Stimulus: reset pulsed mid-operand; then a 0x21 transaction.
- all outputs at reset values.
- 0x21 decoded with count starting from 1.
REQ-037 Stimulus: back-to-back transactions with cs_n high for 4 clock_in cycles.
- both opcodes decoded.
- op_code_valid_out drops between them.
